core_fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the execution unit.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents the fetched instruction plus its PC (feeds the execution unit's old_pc_i) over a valid/ready handshake.
- Consumes the execution unit's branch outputs (new PC offset, is_absolute) to redirect fetch.

---
 rtl/core_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_core_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_unit.sv
// core_fetch_unit: instruction fetch stage. Holds the fetch PC, issues word
// fetches over imem req/ack, presents instructions over valid/ready and
// redirects on branch/jump resolution from the execution unit.
//
// Handshakes:
//   imem:  imem_req_o stays high with a stable imem_addr_o until a cycle with
//          imem_ack_i=1. imem_data_i is valid only in that ack cycle. An ack
//          may arrive in the same cycle the request rises. A request is
//          never withdrawn once raised.
//   instr: instr_o/pc_o are held stable while instr_valid_o=1. The
//          instruction is consumed on a rising edge where
//          instr_valid_o && instr_ready_i, unless a redirect arrives in the
//          same cycle. A redirect drops the held instruction instead.
module core_fetch_unit #(
  parameter int                        MEM_ADDR_WIDTH = 10,
  parameter int                        DATA_WIDTH     = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                      imem_ack_i,
  input  logic [DATA_WIDTH-1:0]     imem_data_i,
  output logic [DATA_WIDTH-1:0]     instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] pc_o,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  input  logic                      redirect_i,
  input  logic [DATA_WIDTH-1:0]     new_pc_offset_i,
  input  logic                      is_absolute_i,
  input  logic [MEM_ADDR_WIDTH-1:0] branch_pc_i,
  output logic                      misalign_o,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [MEM_ADDR_WIDTH-1:0] drain_tgt_q, drain_tgt_d;
  logic [MEM_ADDR_WIDTH-1:0] offset_trunc;
  logic [MEM_ADDR_WIDTH-1:0] raw_target;
  logic [MEM_ADDR_WIDTH-1:0] redirect_target;
  logic                      redirect_misaligned;
  logic                      capture;
  logic                      drop_valid;

  logic [DATA_WIDTH-1:0]     instr_q;
  logic [MEM_ADDR_WIDTH-1:0] pc_q;
  logic                      valid_q;
  logic                      misalign_q;

  // Upper offset bits do not reach the PC; addresses wrap at the PC width.
  logic unused_offset_hi;
  assign unused_offset_hi = ^new_pc_offset_i[DATA_WIDTH-1:MEM_ADDR_WIDTH];

  assign offset_trunc = new_pc_offset_i[MEM_ADDR_WIDTH-1:0];

  // Redirect target: absolute or PC-relative, then forced to word alignment.
  always_comb begin
    raw_target          = is_absolute_i ? offset_trunc : (branch_pc_i + offset_trunc);
    redirect_misaligned = |raw_target[1:0];
    redirect_target     = {raw_target[MEM_ADDR_WIDTH-1:2], 2'b00};
  end

  // State register: FSM state, fetch PC and the target latched during a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      drain_tgt_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drain_tgt_q <= drain_tgt_d;
    end
  end

  // Next-state logic. Redirect outranks ack and ready in every state.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drain_tgt_d = drain_tgt_q;
    capture     = 1'b0;
    drop_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect_i) fetch_pc_d = redirect_target;
      end
      S_FETCH: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            // Data for the wrong path arrives together with the redirect.
            fetch_pc_d = redirect_target;
          end else begin
            // Request in flight cannot be withdrawn; wait it out.
            drain_tgt_d = redirect_target;
            state_d     = S_DRAIN;
          end
        end else if (imem_ack_i) begin
          capture = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect_i) begin
          drop_valid = 1'b1;
          fetch_pc_d = redirect_target;
          state_d    = S_FETCH;
        end else if (instr_ready_i) begin
          drop_valid = 1'b1;
          fetch_pc_d = fetch_pc_q + MEM_ADDR_WIDTH'(4);
          state_d    = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect_i) begin
          // Last redirect wins; stay here until a clean ack retires the stale request.
          drain_tgt_d = redirect_target;
        end else if (imem_ack_i) begin
          fetch_pc_d = drain_tgt_q;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output registers: captured instruction/PC, valid flag, misalign pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_i & redirect_misaligned;
      if (capture) begin
        instr_q <= imem_data_i;
        pc_q    <= fetch_pc_q;
        valid_q <= 1'b1;
      end else if (drop_valid) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_req_o    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr_o   = fetch_pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign misalign_o    = misalign_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_core_fetch_unit.sv
// tb_core_fetch_unit: directed scenarios followed by randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_core_fetch_unit;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RESET_PC = 0;
  localparam int PC_MOD = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_ack_i = 1'b0;
  logic [DW-1:0] imem_data_i = '0;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] pc_o;
  logic          instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [DW-1:0] new_pc_offset_i = '0;
  logic          is_absolute_i = 1'b0;
  logic [AW-1:0] branch_pc_i = '0;
  logic          misalign_o;
  logic [1:0]    dbg_state;

  core_fetch_unit #(
    .MEM_ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC(AW'(RESET_PC))
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .redirect_i(redirect_i),
    .new_pc_offset_i(new_pc_offset_i),
    .is_absolute_i(is_absolute_i),
    .branch_pc_i(branch_pc_i),
    .misalign_o(misalign_o),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_req   : a memory request is outstanding
  // m_stale : the outstanding request belongs to an abandoned path
  // m_hold  : an instruction is being offered downstream
  bit            m_req, m_stale, m_hold, m_mis;
  int            m_pc, m_stale_tgt, m_ipc;
  logic [DW-1:0] m_instr;

  task automatic model_reset();
    m_req = 0; m_stale = 0; m_hold = 0; m_mis = 0;
    m_pc = RESET_PC; m_stale_tgt = RESET_PC; m_ipc = RESET_PC; m_instr = '0;
  endtask

  task automatic model_update(input logic r, input logic a, input logic [31:0] d,
                              input logic rdy, input logic rd, input logic [31:0] off,
                              input logic ab, input logic [AW-1:0] bpc);
    logic [31:0] sum;
    int raw, tgt;
    if (r) begin
      model_reset();
      return;
    end
    sum = ab ? off : (32'(bpc) + off);
    raw = int'(sum % PC_MOD);
    tgt = raw - (raw % 4);
    m_mis = rd && ((raw % 4) != 0);
    if (m_hold) begin
      if (rd) begin
        m_hold = 0; m_pc = tgt; m_req = 1;
      end else if (rdy) begin
        exp_q.push_back(m_instr);
        m_hold = 0; m_pc = (m_pc + 4) % PC_MOD; m_req = 1;
      end
    end else if (!m_req) begin
      m_req = 1;
      if (rd) m_pc = tgt;
    end else if (!m_stale) begin
      if (rd) begin
        if (a) m_pc = tgt;
        else begin m_stale = 1; m_stale_tgt = tgt; end
      end else if (a) begin
        m_hold = 1; m_instr = d; m_ipc = m_pc; m_req = 0;
      end
    end else begin
      if (rd) m_stale_tgt = tgt;
      else if (a) begin m_stale = 0; m_pc = m_stale_tgt; end
    end
  endtask

  task automatic check_outputs();
    check("req", 32'(imem_req_o), 32'(m_req));
    if (m_req) check("addr", 32'(imem_addr_o), 32'(m_pc));
    check("valid", 32'(instr_valid_o), 32'(m_hold));
    check("instr", instr_o, m_instr);
    check("pc", 32'(pc_o), 32'(m_ipc));
    check("misalign", 32'(misalign_o), 32'(m_mis));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: drive, clock, update model, compare.
  task automatic step(input logic r, input logic a, input logic [31:0] d,
                      input logic rdy, input logic rd, input logic [31:0] off,
                      input logic ab, input logic [AW-1:0] bpc);
    logic          obs_consume;
    logic [DW-1:0] obs_instr;
    rst = r; imem_ack_i = a; imem_data_i = d; instr_ready_i = rdy;
    redirect_i = rd; new_pc_offset_i = off; is_absolute_i = ab; branch_pc_i = bpc;
    obs_consume = instr_valid_o && rdy && !rd && !r;
    obs_instr   = instr_o;
    @(posedge clk);
    model_update(r, a, d, rdy, rd, off, ab, bpc);
    if (obs_consume) begin
      if (exp_q.size() == 0) check("consume_q_empty", 32'(exp_q.size()), 32'd1);
      else check("consume", obs_instr, exp_q.pop_front());
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Zero-wait memory returning addr|0xA000.
  task automatic mem_cycle(input logic rdy);
    step(1'b0, 1'(m_req), 32'hA000 | 32'(m_pc), rdy, 1'b0, 32'h0, 1'b0, '0);
  endtask

  task automatic redirect_abs(input logic [31:0] tgt);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, tgt, 1'b1, '0);
  endtask

  task automatic run_to_valid(input int target);
    bit reached = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_hold && m_ipc == target) begin
        reached = 1;
        break;
      end
      mem_cycle(1'b1);
    end
    check("reach_valid", 32'(reached), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);

    // Reset and sequential fetch.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, '0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, '0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_pc", 32'(pc_o), 32'(RESET_PC));
    mem_cycle(1'b1);
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", 32'(imem_addr_o), 32'h000);
    mem_cycle(1'b1);
    check("seq0_instr", instr_o, 32'hA000);
    mem_cycle(1'b1);
    mem_cycle(1'b1);
    check("seq1_instr", instr_o, 32'hA004);
    check("seq1_pc", 32'(pc_o), 32'h004);
    mem_cycle(1'b1);
    mem_cycle(1'b1);
    check("seq2_instr", instr_o, 32'hA008);

    // Backpressure at pc 0x010.
    run_to_valid(32'h010);
    repeat (5) begin
      mem_cycle(1'b0);
      check("bp_pc", 32'(pc_o), 32'h010);
      check("bp_noreq", 32'(imem_req_o), 32'd0);
    end
    mem_cycle(1'b1);
    check("bp_next_addr", 32'(imem_addr_o), 32'h014);

    // Relative redirect from VALID (ready high the same cycle).
    run_to_valid(32'h020);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 10'h01C);
    check("rel_valid", 32'(instr_valid_o), 32'd0);
    check("rel_addr", 32'(imem_addr_o), 32'h014);

    // Absolute redirect.
    run_to_valid(32'h014);
    redirect_abs(32'h100);
    check("abs_addr", 32'(imem_addr_o), 32'h100);

    // Redirect while a wait-state fetch is outstanding.
    run_to_valid(32'h03C);
    mem_cycle(1'b1);
    redirect_abs(32'h200);
    check("drain_addr0", 32'(imem_addr_o), 32'h040);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
    check("drain_addr1", 32'(imem_addr_o), 32'h040);
    check("drain_req", 32'(imem_req_o), 32'd1);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0, '0);
    check("drain_novalid", 32'(instr_valid_o), 32'd0);
    check("drain_newaddr", 32'(imem_addr_o), 32'h200);
    mem_cycle(1'b1);
    check("drain_pc", 32'(pc_o), 32'h200);

    // Misaligned absolute target.
    redirect_abs(32'h103);
    check("mis_pulse", 32'(misalign_o), 32'd1);
    check("mis_addr", 32'(imem_addr_o), 32'h100);
    mem_cycle(1'b1);
    check("mis_clear", 32'(misalign_o), 32'd0);

    // Wrap from the top of the address space.
    redirect_abs(32'h3FC);
    run_to_valid(32'h3FC);
    mem_cycle(1'b1);
    check("wrap_addr", 32'(imem_addr_o), 32'h000);

    // Reset while draining, with ack in the reset cycle.
    redirect_abs(32'h080);
    step(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0, '0);
    check("rstd_req", 32'(imem_req_o), 32'd0);
    check("rstd_valid", 32'(instr_valid_o), 32'd0);
    check("rstd_instr", instr_o, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, '0);
    check("rstd_addr", 32'(imem_addr_o), 32'(RESET_PC));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic          r, a, rdy, rd, ab;
      logic [31:0]   d, off;
      logic [AW-1:0] bpc;
      r   = ($urandom_range(0, 199) == 0);
      a   = m_req && ($urandom_range(0, 1) == 1);
      d   = $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 6) == 0);
      ab  = ($urandom_range(0, 1) == 1);
      off = ab ? 32'($urandom_range(0, 1023)) : $urandom;
      bpc = AW'($urandom_range(0, 255) * 4);
      step(r, a, d, rdy, rd, off, ab, bpc);
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
